// File: rtl/ldst_io_pkg.sv
// Shared definitions for the LDST sequencer IO mailbox: register offsets,
// STATUS bit positions and the register-select type used by the decoder.
package ldst_io_pkg;

   localparam logic [7:0] DATA_OFS   = 8'd0;
   localparam logic [7:0] STATUS_OFS = 8'd1;
   localparam logic [7:0] CTRL_OFS   = 8'd2;

   localparam int ST_RX_NOT_EMPTY = 0;
   localparam int ST_TX_NOT_FULL  = 1;
   localparam int ST_RX_FULL      = 2;
   localparam int ST_TX_EMPTY     = 3;
   localparam int ST_OVERFLOW     = 4;
   localparam int ST_UNDERRUN     = 5;

   typedef enum logic [1:0] {
      REG_DATA,
      REG_STATUS,
      REG_CTRL,
      REG_NONE
   } reg_sel_e;

endpackage

// File: rtl/ldst_sync_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// Pushes into a full FIFO and pops from an empty one are ignored.
module ldst_sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2 + 1)'(1);

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  do_push;
   logic                  do_pop;

   // Full is judged on the registered count, so a same-edge pop never frees room for a push.
   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ldst_io_mailbox.sv
// IO-bus responder exposing a host<->sequencer byte mailbox (RX and TX FIFOs).
// Define LDST_MAILBOX_IRQ_EN to add the CTRL register and the irq output.
module ldst_io_mailbox
   import ldst_io_pkg::*;
#(
   parameter logic [7:0] BASE_ADDR  = 8'h10,
   parameter int         DEPTH_LOG2 = 2
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       io_bus_enable,
   input  logic [7:0] io_bus_address,
   input  logic [7:0] io_bus_data_out,
   input  logic       io_bus_out,
   input  logic       io_bus_in,
   output logic [7:0] io_bus_data_in,
   input  logic [7:0] host_tx_data,
   input  logic       host_tx_valid,
   output logic       host_tx_ready,
   output logic [7:0] host_rx_data,
   output logic       host_rx_valid,
   input  logic       host_rx_ready
`ifdef LDST_MAILBOX_IRQ_EN
   ,
   output logic       irq
`endif
);

   reg_sel_e   reg_sel;
   logic       wr;
   logic       rd;
   logic       rx_full;
   logic       rx_empty;
   logic [7:0] rx_head;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_push;
   logic       rx_pop;
   logic       status_rd;
   logic       overflow;
   logic       underrun;
   logic [7:0] status;

   assign wr = io_bus_enable & io_bus_out;
   assign rd = io_bus_enable & io_bus_in;

   always_comb begin
      reg_sel = REG_NONE;
      if (io_bus_address == BASE_ADDR + DATA_OFS)
         reg_sel = REG_DATA;
      else if (io_bus_address == BASE_ADDR + STATUS_OFS)
         reg_sel = REG_STATUS;
`ifdef LDST_MAILBOX_IRQ_EN
      else if (io_bus_address == BASE_ADDR + CTRL_OFS)
         reg_sel = REG_CTRL;
`endif
   end

   assign tx_push   = wr & (reg_sel == REG_DATA);
   assign rx_pop    = rd & (reg_sel == REG_DATA);
   assign status_rd = rd & (reg_sel == REG_STATUS);

   ldst_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (host_tx_valid),
      .push_data (host_tx_data),
      .pop       (rx_pop),
      .full      (rx_full),
      .empty     (rx_empty),
      .head      (rx_head)
   );

   ldst_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (tx_push),
      .push_data (io_bus_data_out),
      .pop       (host_rx_ready),
      .full      (tx_full),
      .empty     (tx_empty),
      .head      (host_rx_data)
   );

   assign host_tx_ready = ~rx_full;
   assign host_rx_valid = ~tx_empty;

   // A STATUS read clears the sticky flags, but a fresh error on the same edge keeps them set.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         overflow <= 1'b0;
         underrun <= 1'b0;
      end else begin
         overflow <= (overflow & ~status_rd) | (tx_push & tx_full);
         underrun <= (underrun & ~status_rd) | (rx_pop & rx_empty);
      end
   end

   always_comb begin
      status                  = 8'h00;
      status[ST_RX_NOT_EMPTY] = ~rx_empty;
      status[ST_TX_NOT_FULL]  = ~tx_full;
      status[ST_RX_FULL]      = rx_full;
      status[ST_TX_EMPTY]     = tx_empty;
      status[ST_OVERFLOW]     = overflow;
      status[ST_UNDERRUN]     = underrun;
   end

`ifdef LDST_MAILBOX_IRQ_EN
   logic [1:0] ctrl;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ctrl <= 2'b00;
         irq  <= 1'b0;
      end else begin
         if (wr && reg_sel == REG_CTRL) ctrl <= io_bus_data_out[1:0];
         irq <= (ctrl[0] & ~rx_empty) | (ctrl[1] & tx_empty);
      end
   end
`endif

   always_comb begin
      io_bus_data_in = 8'h00;
      if (io_bus_in) begin
         case (reg_sel)
            REG_DATA:   io_bus_data_in = rx_head;
            REG_STATUS: io_bus_data_in = status;
`ifdef LDST_MAILBOX_IRQ_EN
            REG_CTRL:   io_bus_data_in = {6'b000000, ctrl};
`endif
            default:    io_bus_data_in = 8'h00;
         endcase
      end
   end

endmodule

// File: tb/tb_ldst_io_mailbox.sv
// Scoreboard bench for ldst_io_mailbox: stimulus queues expected bytes,
// monitors compare bus read data and host-side transfers as they occur.
module tb_ldst_io_mailbox;

   localparam logic [7:0] BASE   = 8'h10;
   localparam logic [7:0] A_DATA = BASE;
   localparam logic [7:0] A_STAT = BASE + 8'd1;
   localparam logic [7:0] A_CTRL = BASE + 8'd2;

   typedef struct {
      string      name;
      logic [7:0] value;
   } expect_t;

   logic       clock;
   logic       reset_n;
   logic       io_bus_enable;
   logic [7:0] io_bus_address;
   logic [7:0] io_bus_data_out;
   logic       io_bus_out;
   logic       io_bus_in;
   logic [7:0] io_bus_data_in;
   logic [7:0] host_tx_data;
   logic       host_tx_valid;
   logic       host_tx_ready;
   logic [7:0] host_rx_data;
   logic       host_rx_valid;
   logic       host_rx_ready;
`ifdef LDST_MAILBOX_IRQ_EN
   logic       irq;
`endif

   expect_t busQ[$];
   expect_t hostQ[$];
   int      checks   = 0;
   int      failures = 0;

   ldst_io_mailbox #(.BASE_ADDR(BASE), .DEPTH_LOG2(2)) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .io_bus_enable   (io_bus_enable),
      .io_bus_address  (io_bus_address),
      .io_bus_data_out (io_bus_data_out),
      .io_bus_out      (io_bus_out),
      .io_bus_in       (io_bus_in),
      .io_bus_data_in  (io_bus_data_in),
      .host_tx_data    (host_tx_data),
      .host_tx_valid   (host_tx_valid),
      .host_tx_ready   (host_tx_ready),
      .host_rx_data    (host_rx_data),
      .host_rx_valid   (host_rx_valid),
      .host_rx_ready   (host_rx_ready)
`ifdef LDST_MAILBOX_IRQ_EN
      ,
      .irq             (irq)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 8'h%02h, wanted 8'h%02h at %0t", name, actual, expected, $time);
      end
   endtask

   // One bus/host cycle: inputs are held across exactly one rising edge.
   task automatic applyStimulus(input logic en, input logic rd, input logic wr,
                                input logic [7:0] addr, input logic [7:0] wdata,
                                input logic hvalid, input logic [7:0] hdata);
      io_bus_enable   = en;
      io_bus_in       = rd;
      io_bus_out      = wr;
      io_bus_address  = addr;
      io_bus_data_out = wdata;
      host_tx_valid   = hvalid;
      host_tx_data    = hdata;
      @(posedge clock);
      #1;
      io_bus_enable   = 1'b0;
      io_bus_in       = 1'b0;
      io_bus_out      = 1'b0;
      host_tx_valid   = 1'b0;
   endtask

   task automatic busRead(input logic [7:0] addr, input logic [7:0] expected, input string name);
      busQ.push_back('{name, expected});
      applyStimulus(1'b1, 1'b1, 1'b0, addr, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
      applyStimulus(1'b1, 1'b0, 1'b1, addr, data, 1'b0, 8'h00);
   endtask

   task automatic hostPush(input logic [7:0] data);
      applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, data);
   endtask

   // Bus monitor: every qualified read is matched against the next queued expectation.
   always @(negedge clock) begin
      if (reset_n && io_bus_enable && io_bus_in) begin
         if (busQ.size() == 0) begin
            checkOutput("bus_unexpected_read", 8'h01, 8'h00);
         end else begin
            expect_t e;
            e = busQ.pop_front();
            checkOutput(e.name, io_bus_data_in, e.value);
         end
      end
   end

   // Host monitor: every completed TX->host transfer is matched in order.
   always @(negedge clock) begin
      if (reset_n && host_rx_valid && host_rx_ready) begin
         if (hostQ.size() == 0) begin
            checkOutput("host_unexpected_byte", host_rx_data, 8'h00);
            checkOutput("host_unexpected_xfer", 8'h01, 8'h00);
         end else begin
            expect_t e;
            e = hostQ.pop_front();
            checkOutput(e.name, host_rx_data, e.value);
         end
      end
   end

   initial begin
      reset_n         = 1'b0;
      io_bus_enable   = 1'b0;
      io_bus_address  = 8'h00;
      io_bus_data_out = 8'h00;
      io_bus_out      = 1'b0;
      io_bus_in       = 1'b0;
      host_tx_data    = 8'h00;
      host_tx_valid   = 1'b0;
      host_rx_ready   = 1'b0;

      // Reset state
      #12;
      checkOutput("reset_host_tx_ready", {7'd0, host_tx_ready}, 8'h01);
      checkOutput("reset_host_rx_valid", {7'd0, host_rx_valid}, 8'h00);
      checkOutput("reset_host_rx_data", host_rx_data, 8'h00);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      busRead(A_STAT, 8'h0A, "reset_status");

      // Host pushes two bytes; an unqualified read must not pop
      hostPush(8'hA5);
      hostPush(8'h3C);
      applyStimulus(1'b0, 1'b1, 1'b0, A_DATA, 8'h00, 1'b0, 8'h00);
      busRead(A_DATA, 8'hA5, "rx_first_byte");
      busRead(A_DATA, 8'h3C, "rx_second_byte");
      busRead(A_STAT, 8'h0A, "status_after_rx_drain");

      // Fill TX, overflow on the fifth write, then drain on the host side
      busWrite(A_DATA, 8'h11); hostQ.push_back('{"tx_byte0", 8'h11});
      busWrite(A_DATA, 8'h22); hostQ.push_back('{"tx_byte1", 8'h22});
      busWrite(A_DATA, 8'h33); hostQ.push_back('{"tx_byte2", 8'h33});
      busWrite(A_DATA, 8'h44); hostQ.push_back('{"tx_byte3", 8'h44});
      busWrite(A_DATA, 8'h55);
      checkOutput("tx_full_host_rx_data", host_rx_data, 8'h11);
      busRead(A_STAT, 8'h10, "status_overflow_tx_full");
      busRead(A_STAT, 8'h00, "status_overflow_cleared");
      host_rx_ready = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      host_rx_ready = 1'b0;
      checkOutput("tx_drained_valid", {7'd0, host_rx_valid}, 8'h00);
      checkOutput("tx_drained_data", host_rx_data, 8'h00);
      busRead(A_STAT, 8'h0A, "status_after_tx_drain");

      // Underrun on empty RX, sticky until one STATUS read
      busRead(A_DATA, 8'h00, "rx_empty_read");
      busRead(A_STAT, 8'h2A, "status_underrun_set");
      busRead(A_STAT, 8'h0A, "status_underrun_cleared");

      // STATUS writes and undecoded accesses have no effect
      busWrite(A_STAT, 8'hFF);
      busRead(BASE + 8'd3, 8'h00, "undecoded_read");
      busRead(A_STAT, 8'h0A, "status_after_bad_writes");
`ifndef LDST_MAILBOX_IRQ_EN
      busWrite(A_CTRL, 8'hFF);
      busRead(A_CTRL, 8'h00, "ctrl_undecoded_read");
`endif

      // Full RX: simultaneous host push and pop -> push rejected
      hostPush(8'h01);
      hostPush(8'h02);
      hostPush(8'h03);
      hostPush(8'h04);
      checkOutput("rx_full_host_tx_ready", {7'd0, host_tx_ready}, 8'h00);
      busRead(A_STAT, 8'h0F, "status_rx_full");
      busQ.push_back('{"full_pop_with_push", 8'h01});
      applyStimulus(1'b1, 1'b1, 1'b0, A_DATA, 8'h00, 1'b1, 8'h77);
      busRead(A_STAT, 8'h0B, "status_rx_three");
      busRead(A_DATA, 8'h02, "rx_after_reject_0");
      busRead(A_DATA, 8'h03, "rx_after_reject_1");
      busRead(A_DATA, 8'h04, "rx_after_reject_2");
      busRead(A_STAT, 8'h0A, "status_reject_not_stored");

      // Two entries: simultaneous push and pop both succeed
      hostPush(8'hC1);
      hostPush(8'hC2);
      busQ.push_back('{"mid_pop_with_push", 8'hC1});
      applyStimulus(1'b1, 1'b1, 1'b0, A_DATA, 8'h00, 1'b1, 8'hC3);
      busRead(A_STAT, 8'h0B, "status_count_kept");
      busRead(A_DATA, 8'hC2, "rx_mid_0");
      busRead(A_DATA, 8'hC3, "rx_mid_1");
      busRead(A_STAT, 8'h0A, "status_mid_empty");

`ifdef LDST_MAILBOX_IRQ_EN
      // Interrupt generation from rx_irq_en
      busWrite(A_CTRL, 8'h01);
      busRead(A_CTRL, 8'h01, "ctrl_readback");
      checkOutput("irq_rx_empty", {7'd0, irq}, 8'h00);
      hostPush(8'h5A);
      @(posedge clock);
      #1;
      checkOutput("irq_rx_data", {7'd0, irq}, 8'h01);
      busRead(A_DATA, 8'h5A, "irq_rx_byte");
      @(posedge clock);
      #1;
      checkOutput("irq_rx_drained", {7'd0, irq}, 8'h00);
`endif

      // Reset in the middle of a pending TX byte discards it at once
      busWrite(A_DATA, 8'h99);
      checkOutput("pre_reset_rx_valid", {7'd0, host_rx_valid}, 8'h01);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("midreset_rx_valid", {7'd0, host_rx_valid}, 8'h00);
      checkOutput("midreset_rx_data", host_rx_data, 8'h00);
      checkOutput("midreset_tx_ready", {7'd0, host_tx_ready}, 8'h01);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      busRead(A_STAT, 8'h0A, "status_after_midreset");

      repeat (2) @(posedge clock);
      checkOutput("bus_queue_drained", 8'(busQ.size()), 8'h00);
      checkOutput("host_queue_drained", 8'(hostQ.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
